// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the keyboard receiver:
// state encoding, frame constants and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    FAIL      = 3'd6
  } ps2_state_t;

  localparam int         PS2_FRAME_EDGES = 11;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a glitch filter: the output only follows the
// synchronised input after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      filt  <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter driving open-drain clock/data enables.
// Define PS2_TX_RETRY_EN to retry NACKed or timed-out frames up to MAX_RETRIES times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t       state;
  ps2_state_t       state_prev;
  logic             clk_f;
  logic             data_f;
  logic             clk_f_d;
  logic             clk_fall;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  tout_cnt;
  logic [3:0]       bit_cnt;
  logic             armed;
  logic             timeout;
  logic             accept;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_cnt;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_clk_in),
    .filt  (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_data_in),
    .filt  (data_f)
  );

  assign clk_fall = clk_f_d & ~clk_f;
  assign accept   = (state == IDLE) && tx_valid && tx_ready;
  assign armed    = (state == REQ) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout  = armed && (tout_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Byte and parity are captured once; tx_data is ignored afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q   <= tx_data;
      parity_q <= odd_parity(tx_data);
    end
  end

  // Watchdog restarts on each state entry (seen as state != state_prev) and on each device edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_f_d    <= 1'b1;
      state_prev <= IDLE;
      tout_cnt   <= '0;
    end else begin
      clk_f_d    <= clk_f;
      state_prev <= state;
      if (!armed || clk_fall || (state != state_prev)) begin
        tout_cnt <= '0;
      end else if (!timeout) begin
        tout_cnt <= tout_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      inh_cnt     <= '0;
      bit_cnt     <= '0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= INHIBIT;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            inh_cnt    <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt  <= '0;
`endif
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;
            state       <= REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        REQ: begin
          ps2_clk_oe <= 1'b0;
          bit_cnt    <= '0;
          state      <= SEND;
        end
        SEND: begin
          if (timeout) begin
            state <= FAIL;
          end else if (clk_fall) begin
            // bit_cnt holds edge-1 here: 0..7 data, 8 parity, 9 stop.
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              ps2_data_oe <= ~data_q[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              ps2_data_oe <= ~parity_q;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
        end
        ACK: begin
          if (timeout) begin
            state <= FAIL;
          end else if (clk_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            state   <= data_f ? FAIL : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (timeout) begin
            state <= FAIL;
          end else if (clk_f && data_f) begin
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        FAIL: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
          retry_cnt <= retry_cnt + 2'd1;
          if (int'(retry_cnt) + 1 <= MAX_RETRIES) begin
            ps2_clk_oe <= 1'b1;
            inh_cnt    <= '0;
            state      <= INHIBIT;
          end else begin
            tx_error <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
`else
          tx_error <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
`endif
        end
        default: begin
          state       <= IDLE;
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, table of frames, and hand-written
// timeout, reset-abort and randomized sequences.
module tb_ps2_host_tx;

  localparam int INH  = 3000;
  localparam int TOUT = 4000;
  localparam int H    = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int NACK_FRAMES = 3;
`else
  localparam int NACK_FRAMES = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TOUT),
    .FILTER_LEN     (4),
    .MAX_RETRIES    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog: simulation time limit reached, got no $finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      ones += int'((d >> i) & 8'd1);
      f[i+1] = ((d >> i) & 8'd1) != 0;
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_request(output bit ok);
    int t;
    t = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < 10000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 10000);
  endtask

  task automatic dev_frame(input bit ack, input int gk, output logic [10:0] bits, output bit ok);
    bits = '1;
    wait_request(ok);
    if (ok) begin
      bits[0] = ps2_data_in;
      for (int k = 1; k <= 11; k++) begin
        if (k == 11) dev_data_low = ack;
        if (k == gk) begin
          repeat (H / 2) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (2) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (H / 2 - 2) @(negedge clk);
        end else begin
          repeat (H) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        if (k <= 10) bits[k] = ps2_data_in;
        dev_clk_low = 1'b0;
      end
      repeat (H) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic measure_inhibit(output int inh, output int req);
    bit stop;
    inh = 0;
    req = 0;
    stop = 0;
    for (int i = 0; i < INH + 200 && !stop; i++) begin
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      else if (ps2_clk_oe && ps2_data_oe) req++;
      else if (req > 0) stop = 1;
      if (!stop) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         glitch;
    bit         poke;
    int         exp_done;
    int         exp_err;
  } vec_t;

  task automatic send(input vec_t v, input string nm);
    int nfr, inh, req, d0, e0;
    logic [10:0] got[3];
    bit okf[3];
    bit extra;
    nfr = v.ack ? 1 : NACK_FRAMES;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data = v.data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    fork
      measure_inhibit(inh, req);
      begin
        for (int f = 0; f < nfr; f++) dev_frame(v.ack, v.glitch, got[f], okf[f]);
      end
      begin
        if (v.poke) begin
          repeat (100) @(negedge clk);
          tx_data = 8'h3C;
          tx_valid = 1'b1;
          repeat (4) @(negedge clk);
          tx_valid = 1'b0;
        end
      end
    join
    chk({nm, "_inhibit_cycles"}, inh, INH);
    chk({nm, "_req_cycles"}, req, 1);
    for (int f = 0; f < nfr; f++) begin
      chk({nm, "_request_seen"}, okf[f], 1);
      chk({nm, "_frame_bits"}, got[f], model_frame(v.data));
    end
    for (int i = 0; i < 200 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({nm, "_done_pulses"}, done_cnt - d0, v.exp_done);
    chk({nm, "_error_pulses"}, err_cnt - e0, v.exp_err);
    chk({nm, "_ready_after"}, {tx_ready, busy}, 2'b10);
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      if (ps2_clk_oe) extra = 1;
      @(negedge clk);
    end
    chk({nm, "_no_extra_frame"}, extra, 0);
  endtask

  task automatic dev_partial(input int n, output bit ok);
    wait_request(ok);
    if (ok) begin
      for (int k = 1; k <= n; k++) begin
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b1;
        if (k < n) begin
          repeat (H) @(negedge clk);
          dev_clk_low = 1'b0;
        end
      end
      repeat (12) @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs[5];
    vec_t rv;
    bit ok;
    int t, cnt, d0, e0;

    vecs[0] = '{data: 8'hED, ack: 1, glitch: 0, poke: 0, exp_done: 1, exp_err: 0};
    vecs[1] = '{data: 8'h01, ack: 1, glitch: 0, poke: 1, exp_done: 1, exp_err: 0};
    vecs[2] = '{data: 8'h00, ack: 1, glitch: 0, poke: 1, exp_done: 1, exp_err: 0};
    vecs[3] = '{data: 8'hA5, ack: 0, glitch: 0, poke: 0, exp_done: 0, exp_err: 1};
    vecs[4] = '{data: 8'h5A, ack: 1, glitch: 4, poke: 0, exp_done: 1, exp_err: 0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 6'b100000);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_outputs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);

    for (int i = 0; i < 5; i++) send(vecs[i], $sformatf("vec%0d", i));

    // Device never clocks: each attempt must time out TOUT cycles after clock release.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data = 8'h42;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int a = 0; a < NACK_FRAMES; a++) begin
      t = 0;
      while (!(ps2_clk_oe && ps2_data_oe) && t < 5000) begin @(negedge clk); t++; end
      while (ps2_clk_oe && t < 5000) begin @(negedge clk); t++; end
      chk("timeout_req_reached", t < 5000, 1);
      cnt = 0;
      while (!(tx_error || ps2_clk_oe) && cnt < TOUT + 50) begin @(negedge clk); cnt++; end
      chk("timeout_latency", (cnt >= TOUT) && (cnt <= TOUT + 4), 1);
    end
    chk("timeout_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    repeat (3) @(negedge clk);
    chk("timeout_error_pulses", err_cnt - e0, 1);
    chk("timeout_no_done", done_cnt - d0, 0);

    // Reset in the middle of a frame, just after device edge 5.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_partial(5, ok);
    chk("reset_req_seen", ok, 1);
    chk("pre_reset_data_oe", ps2_data_oe, 1);
    #3 reset = 1'b1;
    #1 chk("async_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("ready_after_reset", {tx_ready, busy}, 2'b10);
    chk("no_pulse_on_reset", (done_cnt - d0) + (err_cnt - e0), 0);
    rv = '{data: 8'hFF, ack: 1, glitch: 0, poke: 0, exp_done: 1, exp_err: 0};
    send(rv, "after_reset_ff");

    for (int i = 0; i < 3; i++) begin
      rv = '{data: 8'($urandom), ack: 1, glitch: int'($urandom_range(0, 10)), poke: 0,
             exp_done: 1, exp_err: 0};
      send(rv, $sformatf("rand%0d", i));
    end

    chk("done_error_exclusive", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
